// File: rtl/alu_cmd_ctrl.sv
// Command-serialising controller in front of a combinational 32-bit ALU.
// Owns an 8x32 register file (entry 0 reads zero) and a response port.
module alu_cmd_ctrl #(
   parameter int NREGS = 8,
   localparam int IW = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [2:0]    cmd_op,
   input  logic [IW-1:0] cmd_rd,
   input  logic [IW-1:0] cmd_rs1,
   input  logic [IW-1:0] cmd_rs2,
   input  logic [31:0]   cmd_imm,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [2:0]    alu_sel,
   input  logic [31:0]   alu_out,
   input  logic          alu_zero,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_data,
   output logic          rsp_zero,
   output logic [IW-1:0] rsp_rd,
   output logic          rsp_err
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [31:0]   rf [NREGS];
   logic [31:0]   rs1_val;
   logic [31:0]   rs2_val;
   logic [IW-1:0] rd_q;
   logic          load_q;
   logic [31:0]   imm_q;
   logic          err_q;
   logic          accept;
   logic          exec;
   logic [31:0]   result;
   logic          res_zero;

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign accept    = cmd_valid & cmd_ready;
   assign exec      = (state_q == EXEC);

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         (state_q == IDLE): if (cmd_valid) state_d = EXEC;
         (state_q == EXEC): state_d = RESP;
         (state_q == RESP): if (rsp_ready) state_d = IDLE;
         default:           state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Entry 0 is never written, but the read mux forces zero regardless.
   always_comb begin
      rs1_val = (cmd_rs1 == '0) ? 32'd0 : rf[cmd_rs1];
      rs2_val = (cmd_rs2 == '0) ? 32'd0 : rf[cmd_rs2];
   end

   always_comb begin
      result   = load_q ? imm_q : alu_out;
      res_zero = load_q ? (imm_q == 32'd0) : alu_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         rd_q    <= '0;
         load_q  <= 1'b0;
         imm_q   <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         alu_a   <= rs1_val;
         alu_b   <= rs2_val;
         alu_sel <= cmd_op;
         rd_q    <= cmd_rd;
         load_q  <= cmd_load;
         imm_q   <= cmd_imm;
         err_q   <= (cmd_op >= 3'b110);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rsp_rd   <= '0;
         rsp_err  <= 1'b0;
      end else if (exec) begin
         rsp_data <= result;
         rsp_zero <= res_zero;
         rsp_rd   <= rd_q;
         rsp_err  <= err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (exec && (rd_q != '0)) begin
         rf[rd_q] <= result;
      end
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a bench-side ALU and a
// transaction-level model checked against the DUT every cycle.
module tb_alu_cmd_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_load;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_rd;
   logic [2:0]  cmd_rs1;
   logic [2:0]  cmd_rs2;
   logic [31:0] cmd_imm;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_sel;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_zero;
   logic [2:0]  rsp_rd;
   logic        rsp_err;

   int total = 0;
   int bad = 0;
   int hs = 0;

   alu_cmd_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_load(cmd_load), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .rsp_rd(rsp_rd), .rsp_err(rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] alu_f(input logic [2:0] s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_out  = alu_f(alu_sel, alu_a, alu_b);
   assign alu_zero = (alu_out == 32'd0);

   function automatic logic [31:0] model_res(input logic ld,
                                             input logic [2:0] op,
                                             input logic [31:0] imm,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      return ld ? imm : alu_f(op, a, b);
   endfunction

   // Transaction model: a command is in flight from accept until taken;
   // its answer is visible one cycle after accept.
   logic [31:0] m_rf [8];
   logic        have_cmd;
   logic        answered;
   logic [31:0] exp_a, exp_b, exp_data;
   logic [2:0]  exp_sel, exp_rd;
   logic        exp_zero, exp_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_rf[i] <= 32'd0;
         have_cmd <= 1'b0;
         answered <= 1'b0;
      end else if (!have_cmd) begin
         if (cmd_valid) begin
            have_cmd <= 1'b1;
            answered <= 1'b0;
            exp_a    <= m_rf[cmd_rs1];
            exp_b    <= m_rf[cmd_rs2];
            exp_sel  <= cmd_op;
            exp_rd   <= cmd_rd;
            exp_err  <= (cmd_op >= 3'd6);
            exp_data <= model_res(cmd_load, cmd_op, cmd_imm,
                                  m_rf[cmd_rs1], m_rf[cmd_rs2]);
            exp_zero <= (model_res(cmd_load, cmd_op, cmd_imm,
                         m_rf[cmd_rs1], m_rf[cmd_rs2]) == 32'd0);
            if (cmd_rd != 3'd0)
               m_rf[cmd_rd] <= model_res(cmd_load, cmd_op, cmd_imm,
                                         m_rf[cmd_rs1], m_rf[cmd_rs2]);
         end
      end else if (!answered) begin
         answered <= 1'b1;
      end else if (rsp_ready) begin
         have_cmd <= 1'b0;
         answered <= 1'b0;
      end
   end

   always @(posedge clk)
      if (rst_n && rsp_valid && rsp_ready) hs <= hs + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_a", alu_a, 32'd0);
         chk("rst_b", alu_b, 32'd0);
         chk("rst_sel", {29'd0, alu_sel}, 32'd0);
         chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_data", rsp_data, 32'd0);
      end else begin
         chk("m_ready", {31'd0, cmd_ready}, {31'd0, !have_cmd});
         chk("m_valid", {31'd0, rsp_valid}, {31'd0, answered});
         if (have_cmd) begin
            chk("m_alu_a", alu_a, exp_a);
            chk("m_alu_b", alu_b, exp_b);
            chk("m_alu_sel", {29'd0, alu_sel}, {29'd0, exp_sel});
         end
         if (answered) begin
            chk("m_data", rsp_data, exp_data);
            chk("m_zero", {31'd0, rsp_zero}, {31'd0, exp_zero});
            chk("m_rd", {29'd0, rsp_rd}, {29'd0, exp_rd});
            chk("m_err", {31'd0, rsp_err}, {31'd0, exp_err});
         end
      end
   end

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s timeout got=0 want=1", nm);
   endtask

   task automatic send(input logic ld, input logic [2:0] op,
                       input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] imm);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) timeout("cmd_ready");
      cmd_valid = 1'b1;
      cmd_load  = ld;
      cmd_op    = op;
      cmd_rd    = rd;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      cmd_imm   = imm;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) timeout("rsp_valid");
   endtask

   task automatic cmd(input string nm, input logic ld,
                      input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ed,
                      input logic ez, input logic ee);
      send(ld, op, rd, rs1, rs2, imm);
      wait_rsp();
      chk({nm, "_data"}, rsp_data, ed);
      chk({nm, "_zero"}, {31'd0, rsp_zero}, {31'd0, ez});
      chk({nm, "_rd"}, {29'd0, rsp_rd}, {29'd0, rd});
      chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, ee});
      @(posedge clk); #1;
   endtask

   int h0;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_load  = 1'b0;
      cmd_op    = 3'd0;
      cmd_rd    = 3'd0;
      cmd_rs1   = 3'd0;
      cmd_rs2   = 3'd0;
      cmd_imm   = 32'd0;
      rsp_ready = 1'b1;
      #2;
      chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_data", rsp_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;

      cmd("ld1", 1, 3'd0, 3'd1, 3'd0, 3'd0, 32'h5, 32'h5, 0, 0);
      cmd("ld2", 1, 3'd0, 3'd2, 3'd0, 3'd0, 32'h3, 32'h3, 0, 0);
      cmd("add", 0, 3'd0, 3'd3, 3'd1, 3'd2, 32'h0, 32'h8, 0, 0);
      cmd("rd_r3", 0, 3'd0, 3'd6, 3'd3, 3'd0, 32'h0, 32'h8, 0, 0);
      cmd("sub", 0, 3'd1, 3'd4, 3'd2, 3'd1, 32'h0,
          32'hFFFF_FFFE, 0, 0);
      cmd("sub0", 0, 3'd1, 3'd5, 3'd1, 3'd1, 32'h0, 32'h0, 1, 0);

      cmd("ld1b", 1, 3'd0, 3'd1, 3'd0, 3'd0, 32'hF0F0_F0F0,
          32'hF0F0_F0F0, 0, 0);
      cmd("ld2b", 1, 3'd0, 3'd2, 3'd0, 3'd0, 32'h0FF0_0FF0,
          32'h0FF0_0FF0, 0, 0);
      cmd("and", 0, 3'd2, 3'd3, 3'd1, 3'd2, 32'h0,
          32'h00F0_00F0, 0, 0);
      cmd("or", 0, 3'd3, 3'd3, 3'd1, 3'd2, 32'h0,
          32'hFFF0_FFF0, 0, 0);
      cmd("xor", 0, 3'd4, 3'd3, 3'd1, 3'd2, 32'h0,
          32'hFF00_FF00, 0, 0);
      cmd("nor", 0, 3'd5, 3'd3, 3'd1, 3'd2, 32'h0,
          32'h000F_000F, 0, 0);

      cmd("ld1c", 1, 3'd0, 3'd1, 3'd0, 3'd0, 32'h5, 32'h5, 0, 0);
      cmd("ld2c", 1, 3'd0, 3'd2, 3'd0, 3'd0, 32'h3, 32'h3, 0, 0);
      cmd("wr_r0", 0, 3'd0, 3'd0, 3'd1, 3'd2, 32'h0, 32'h8, 0, 0);
      cmd("rd_r0", 0, 3'd0, 3'd7, 3'd0, 3'd0, 32'h0, 32'h0, 1, 0);
      cmd("bad_op", 0, 3'd7, 3'd6, 3'd1, 3'd2, 32'h0, 32'h0, 1, 1);

      rsp_ready = 1'b0;
      send(0, 3'd0, 3'd3, 3'd1, 3'd2, 32'h0);
      wait_rsp();
      h0 = hs;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'h8);
         chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs", hs, h0 + 1);
      chk("bp_valid_off", {31'd0, rsp_valid}, 32'd0);
      chk("bp_ready_on", {31'd0, cmd_ready}, 32'd1);

      h0 = hs;
      send(0, 3'd0, 3'd3, 3'd1, 3'd2, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_a", alu_a, 32'd0);
      chk("ar_b", alu_b, 32'd0);
      chk("ar_sel", {29'd0, alu_sel}, 32'd0);
      chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
      chk("ar_data", rsp_data, 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ar_ready", {31'd0, cmd_ready}, 32'd1);
      chk("ar_no_rsp", hs, h0);
      @(posedge clk); #1;
      chk("ar_valid2", {31'd0, rsp_valid}, 32'd0);
      cmd("ar_rf", 0, 3'd0, 3'd4, 3'd1, 3'd2, 32'h0, 32'h0, 1, 0);
      cmd("ar_rf3", 0, 3'd0, 3'd5, 3'd3, 3'd0, 32'h0, 32'h0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-driven controller that issues operations to the team's combinational 32-bit ALU and returns results. Holds an 8-entry × 32-bit register file and accepts one command at a time on a valid/ready interface. It drives the ALU operand and select inputs from registers, captures the ALU result and zero flag, writes the result back, and presents a response on a second valid/ready interface. It is the initiator side of the ALU port (A, B, select in; result, zero out).

## Interface
- NREGS, 8, register file depth; index width is log2(NREGS) = 3. Entry 0 is hardwired zero.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_load  in  1  1 = load immediate into rd; 0 = ALU operation
- cmd_op  in  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor
- cmd_rd / cmd_rs1 / cmd_rs2  in  3 each  destination and source register indices
- cmd_imm  in  32  immediate, used only when cmd_load=1
- alu_a / alu_b  out  32  registered operands to the ALU
- alu_sel  out  3  registered select to the ALU
- alu_out  in  32  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  result value
- rsp_zero  out  1  result == 0
- rsp_rd  out  3  destination index of this result
- rsp_err  out  1  cmd_op was 110 or 111 (unsupported)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch:
    - alu_a ← R[rs1] and alu_b ← R[rs2], where R[0] reads 0.
    - alu_sel ← cmd_op.
    - rd, load flag, immediate, and err = (cmd_op ≥ 110).
  - Go to EXEC.
- EXEC (exactly one cycle), cmd_ready = 0:
  - If load: result = imm, zero = (imm == 0). The ALU inputs are don't-care, but alu_a, alu_b and alu_sel still hold their latched values.
  - Otherwise: result = alu_out, zero = alu_zero.
  - Register result into rsp_data and rsp_zero.
  - Write R[rd] ← result unless rd == 0.
  - Go to RESP.
- RESP: rsp_valid = 1; rsp_data, rsp_zero, rsp_rd and rsp_err are held stable. On rsp_ready, go to IDLE.
- Unsupported op: still executed. The ALU returns 0, which is written back and reported with rsp_err = 1 and rsp_zero = 1.
- Arithmetic wraps modulo 2^32. No carry or overflow output.
- Write to rd = 0: rsp_data still reports the computed value; R[0] stays 0.
- Commands are strictly serialized, so there is no read-after-write hazard: the next command reads the updated register file.
- Reset (any state, any time):
  - State goes to IDLE.
  - All registers R[0..7] are cleared.
  - alu_a, alu_b, alu_sel, rsp_data, rsp_rd, rsp_err and rsp_valid all go to 0; rsp_zero goes to 0.
  - cmd_ready = 1 once rst_n is high.
  - Any in-flight command is dropped with no response.

## Timing
- cmd_ready and rsp_valid are pure state decodes (registered state), with no combinational path from cmd_valid or rsp_ready.
- Accept at edge N → EXEC during cycle N..N+1. Register write and rsp capture happen at edge N+1; rsp_valid is high from edge N+1.
- Minimum spacing is one command per 3 cycles when rsp_ready is held 1: accept at N, respond visible N+1, response taken at N+2, next accept at edge N+3.
- Back-pressure: rsp_ready low holds RESP indefinitely with outputs stable; cmd_ready stays 0.
- alu_a, alu_b and alu_sel change only on command accept and stay stable through EXEC and RESP.

## Test plan
- Reset check, then load R1 ← 0x0000_0005 and R2 ← 0x0000_0003; ADD rd=3, rs1=1, rs2=2 → rsp_data = 8, rsp_zero = 0, rsp_rd = 3; a later read of R3 via ADD R3+R0 returns 8.
- SUB R4 ← R2 − R1 → rsp_data = 0xFFFF_FFFE. Then SUB R5 ← R1 − R1 → rsp_data = 0, rsp_zero = 1.
- Load R1 ← 0xF0F0_F0F0 and R2 ← 0x0FF0_0FF0, then run each logic op:
  - AND → 0x00F0_00F0
  - OR → 0xFFF0_FFF0
  - XOR → 0xFF00_FF00
  - NOR → 0x000F_000F
- Write to R0 (ADD rd=0 of 5+3) → rsp_data = 8; next ADD R0+R0 → 0 with rsp_zero = 1. Op 111 → rsp_err = 1, rsp_data = 0, rsp_zero = 1.
- Back-pressure: hold rsp_ready = 0 for 5 cycles → rsp_valid stays 1, rsp_data stable, cmd_ready = 0. Release → exactly one handshake, then cmd_ready = 1 next cycle.
- Assert rst_n low during EXEC → all outputs 0 asynchronously, no response issued, registers read 0 afterward, cmd_ready = 1 after release.
